// File: rtl/io_conditioner_pkg.sv
// Shared defaults and sizing helper for the io_conditioner input-conditioning block.
package io_conditioner_pkg;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_FILTER_CYCLES = 16;
    localparam int DEF_RESET_HOLD    = 16;

    // Counter width for a count range of n states, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/io_cond_channel.sv
// One conditioned input: metastability synchronizer, persistence glitch filter
// and registered rise/fall pulses on the filtered level.
module io_cond_channel
    import io_conditioner_pkg::*;
#(
    parameter int   SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int   FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter logic INIT          = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    localparam int            CW        = cnt_w(FILTER_CYCLES);
    localparam logic [CW-1:0] CNT_LAST  = CW'((FILTER_CYCLES > 1) ? FILTER_CYCLES - 1 : 0);
    localparam bit            NO_FILTER = (FILTER_CYCLES <= 1);

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   s_p0;
    logic                   differ_p0;
    logic                   load_p0;
    logic [CW-1:0]          cnt_p1;
    logic                   level_p1;
    logic                   rise_p1;
    logic                   fall_p1;

    // Stage 0: synchronizer chain, oldest sample at the top bit
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= {SYNC_STAGES{INIT}};
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
        end
    end

    assign s_p0 = sync_p0[SYNC_STAGES-1];

    always_comb begin
        differ_p0 = (s_p0 != level_p1);
        load_p0   = differ_p0 && (NO_FILTER || (cnt_p1 == CNT_LAST));
    end

    // Stage 1: filtered level and its edge pulses update on the same edge
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p1   <= '0;
            level_p1 <= INIT;
            rise_p1  <= 1'b0;
            fall_p1  <= 1'b0;
        end else begin
            rise_p1 <= load_p0 & s_p0;
            fall_p1 <= load_p0 & ~s_p0;
            if (load_p0) begin
                level_p1 <= s_p0;
                cnt_p1   <= '0;
            end else if (differ_p0) begin
                cnt_p1   <= cnt_p1 + CW'(1);
            end else begin
                cnt_p1   <= '0;
            end
        end
    end

    assign dout = level_p1;
    assign rise = rise_p1;
    assign fall = fall_p1;

endmodule

// File: rtl/io_conditioner.sv
// Conditions N asynchronous inputs into clean levels and edge pulses, and
// stretches the incoming reset into a longer reset for downstream logic.
module io_conditioner
    import io_conditioner_pkg::*;
#(
    parameter int           N             = 2,
    parameter int           SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int           FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter logic [N-1:0] INIT          = '1,
    parameter int           RESET_HOLD    = DEF_RESET_HOLD
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] din,
    output logic [N-1:0] dout,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic         reset_out
);

    localparam int            HW      = cnt_w(RESET_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LD = HW'(RESET_HOLD);

    logic [HW-1:0] hold_p0;
    logic          hold_out_p1;

    for (genvar i = 0; i < N; i++) begin : g_ch
        io_cond_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES),
            .INIT         (INIT[i])
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .din  (din[i]),
            .dout (dout[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    // Stage 0/1: hold counter reloads while reset is high, drains after release
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_p0     <= HOLD_LD;
            hold_out_p1 <= 1'b1;
        end else begin
            hold_out_p1 <= (hold_p0 != '0);
            if (hold_p0 != '0) begin
                hold_p0 <= hold_p0 - HW'(1);
            end
        end
    end

    // The OR keeps reset_out high from the very first cycle reset is asserted.
    assign reset_out = reset | hold_out_p1;

endmodule

// File: tb/tb_io_conditioner.sv
// Directed bench for io_conditioner: a filtered build (FILTER_CYCLES=4) and an
// unfiltered build (FILTER_CYCLES=0) driven from one clock and reset.
module tb_io_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] din, dout, rise, fall;
    logic       reset_out;
    logic [1:0] nf_din, nf_dout, nf_rise, nf_fall;
    logic       nf_reset_out;

    int checks = 0;
    int errors = 0;
    int rise_cnt [2];
    int fall_cnt [2];
    int both_hi;
    int dout_low;
    int nf_low, nf_rise_cnt, nf_fall_cnt;

    always #5 clk = ~clk;

    io_conditioner #(
        .N(2), .SYNC_STAGES(2), .FILTER_CYCLES(4), .INIT(2'b11), .RESET_HOLD(3)
    ) dut (
        .clk(clk), .reset(reset), .din(din), .dout(dout),
        .rise(rise), .fall(fall), .reset_out(reset_out)
    );

    io_conditioner #(
        .N(2), .SYNC_STAGES(2), .FILTER_CYCLES(0), .INIT(2'b11), .RESET_HOLD(3)
    ) dut_nf (
        .clk(clk), .reset(reset), .din(nf_din), .dout(nf_dout),
        .rise(nf_rise), .fall(nf_fall), .reset_out(nf_reset_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_stats();
        rise_cnt[0] = 0; rise_cnt[1] = 0;
        fall_cnt[0] = 0; fall_cnt[1] = 0;
        both_hi = 0; dout_low = 0;
        nf_low = 0; nf_rise_cnt = 0; nf_fall_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rise[i]) rise_cnt[i]++;
            if (fall[i]) fall_cnt[i]++;
        end
        if ((rise & fall) != 2'b00) both_hi++;
        if (!dout[0]) dout_low++;
        if (!nf_dout[0]) nf_low++;
        if (nf_rise[0]) nf_rise_cnt++;
        if (nf_fall[0]) nf_fall_cnt++;
    endtask

    initial begin
        reset  = 1'b1;
        din    = 2'b11;
        nf_din = 2'b11;
        clr_stats();

        // reset state and stretch timing
        repeat (5) tick();
        check("rst_out_in_reset", reset_out, 1);
        check("dout_in_reset", dout, 2'b11);
        check("rise_in_reset", rise, 0);
        check("fall_in_reset", fall, 0);
        check("nf_dout_in_reset", nf_dout, 2'b11);
        check("nf_rst_out_in_reset", nf_reset_out, 1);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("rst_hold_e%0d", k), reset_out, (k < 4) ? 1 : 0);
        end
        check("dout_after_rst", dout, 2'b11);
        check("pulses_after_rst", rise_cnt[0] + rise_cnt[1] + fall_cnt[0] + fall_cnt[1], 0);
        clr_stats();

        // held 1->0 on channel 0, both builds
        din    = 2'b10;
        nf_din = 2'b10;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 2) check("nf_dout_e2", nf_dout, 2'b11);
            if (k == 3) begin
                check("nf_dout_e3", nf_dout, 2'b10);
                check("nf_fall_e3", nf_fall, 2'b01);
            end
            if (k == 5) check("dout_e5", dout, 2'b11);
            if (k == 6) begin
                check("dout_e6", dout, 2'b10);
                check("fall_e6", fall, 2'b01);
                check("rise_e6", rise, 2'b00);
            end
            if (k == 7) check("fall_e7", fall, 2'b00);
        end
        check("fall0_count", fall_cnt[0], 1);
        check("fall1_count", fall_cnt[1], 0);
        check("rise_count", rise_cnt[0] + rise_cnt[1], 0);
        din    = 2'b11;
        nf_din = 2'b11;
        repeat (10) tick();
        check("dout_restored", dout, 2'b11);
        check("rise0_restored", rise_cnt[0], 1);
        check("nf_dout_restored", nf_dout, 2'b11);
        clr_stats();

        // 3-clock glitch is filtered; 1-clock glitch passes unfiltered build
        din    = 2'b10;
        nf_din = 2'b10;
        tick();
        nf_din = 2'b11;
        tick();
        tick();
        din = 2'b11;
        repeat (10) tick();
        check("glitch3_dout_low", dout_low, 0);
        check("glitch3_fall", fall_cnt[0], 0);
        check("glitch3_rise", rise_cnt[0], 0);
        check("nf_glitch_low", nf_low, 1);
        check("nf_glitch_fall", nf_fall_cnt, 1);
        check("nf_glitch_rise", nf_rise_cnt, 1);
        clr_stats();

        // 4-clock low passes the filter and returns
        din = 2'b10;
        repeat (4) tick();
        din = 2'b11;
        repeat (10) tick();
        check("pulse4_dout_low", dout_low, 4);
        check("pulse4_fall", fall_cnt[0], 1);
        check("pulse4_rise", rise_cnt[0], 1);
        check("pulse4_dout_end", dout, 2'b11);
        check("pulse4_both_hi", both_hi, 0);
        clr_stats();

        // simultaneous change on both channels
        din = 2'b00;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 6) begin
                check("both_dout_low", dout, 2'b00);
                check("both_fall", fall, 2'b11);
            end
        end
        din = 2'b11;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 6) begin
                check("both_dout_high", dout, 2'b11);
                check("both_rise", rise, 2'b11);
            end
        end
        check("both_never_together", both_hi, 0);
        clr_stats();

        // reset while channel 1 filter count is 2
        din = 2'b01;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("midrst_dout", dout, 2'b11);
        check("midrst_fall", fall, 2'b00);
        check("midrst_fall1_count", fall_cnt[1], 0);
        check("midrst_rst_out", reset_out, 1);
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 4) check("midrst_rst_out_e4", reset_out, 0);
            if (k == 5) check("midrst_dout_e5", dout, 2'b11);
            if (k == 6) begin
                check("midrst_dout_e6", dout, 2'b01);
                check("midrst_fall_e6", fall, 2'b10);
            end
        end
        check("midrst_fall1_total", fall_cnt[1], 1);
        din = 2'b11;
        repeat (10) tick();
        clr_stats();

        // reset re-asserted one cycle into the hold
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("rehold_e1", reset_out, 1);
        reset = 1'b1;
        tick();
        check("rehold_reasserted", reset_out, 1);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("rehold_e%0d", k), reset_out, (k < 4) ? 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_conditioner.md
IO_CONDITIONER -- requirements
Module: io_conditioner

Interface
REQ-001 Parameter N, default 2, number of asynchronous input channels (N >= 1).
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flop depth per channel (>= 2).
REQ-003 Parameter FILTER_CYCLES, default 16, glitch-filter length in clocks; 0 and 1 both mean no filtering.
REQ-004 Parameter INIT, default all-ones N bits, reset value per channel (UART idle-high).
REQ-005 Parameter RESET_HOLD, default 16, extra clocks reset_out stays high after reset falls.
REQ-006 clk  input  1  single system clock; all logic on posedge clk.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 din  input  N  raw asynchronous inputs, e.g. uart_rx or buttons.
REQ-009 dout  output  N  synchronized, filtered level per channel.
REQ-010 rise  output  N  one-cycle pulse on a 0->1 change of dout[i].
REQ-011 fall  output  N  one-cycle pulse on a 1->0 change of dout[i].
REQ-012 reset_out  output  1  stretched, clean reset for downstream logic such as mother_board.

Function
REQ-013 Each channel SHALL pass din[i] through SYNC_STAGES flops; synced value s[i] reflects din[i] SYNC_STAGES edges after the change.
REQ-014 Each channel SHALL hold a filter counter, width $clog2(max(FILTER_CYCLES,2)); it clears whenever s[i] == dout[i].
REQ-015 While s[i] != dout[i] and counter < FILTER_CYCLES-1, the counter SHALL increment by 1 per clock.
REQ-016 When s[i] != dout[i] and counter == FILTER_CYCLES-1, or FILTER_CYCLES <= 1, dout[i] SHALL load s[i] on that edge and the counter SHALL clear.
REQ-017 Latency from a stable din change to dout: SYNC_STAGES + max(FILTER_CYCLES,1) clock edges.
REQ-018 A change of s[i] lasting fewer than FILTER_CYCLES consecutive clocks SHALL NOT alter dout[i] and SHALL NOT produce pulses.
REQ-019 rise[i]/fall[i] SHALL be registered and asserted for exactly the first cycle in which dout[i] shows its new value; never both high together.
REQ-020 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each follow REQ-013..019.
REQ-021 Reset stretcher: hold counter loads RESET_HOLD while reset is high; reset_out SHALL be 1 while reset is high.
REQ-022 After reset is sampled low, the counter SHALL decrement per clock; reset_out SHALL fall on edge RESET_HOLD+1 after the first low-sampled edge.
REQ-023 Reset re-asserted during the hold SHALL restart the hold from RESET_HOLD.

Reset
REQ-024 On reset: all sync flops and dout = INIT, filter counters = 0, rise = fall = 0, reset_out = 1.
REQ-025 Reset mid-filter SHALL discard the pending change with no pulse; the first post-reset edge compares against INIT.

Structure
REQ-026 Package io_conditioner_pkg SHALL hold default parameter constants (sync depth, filter length, hold length) and the counter-width helper function.
REQ-027 One sub-module io_cond_channel (sync chain, filter, edge pulses) SHALL be instantiated N times via generate; the reset stretcher SHALL stay in io_conditioner.
REQ-028 No combinational path from din to any output.

Verification (N=2, SYNC_STAGES=2, FILTER_CYCLES=4, RESET_HOLD=3, INIT=2'b11)
REQ-029 reset high 5 cycles then low, din=2'b11 -> dout=2'b11, rise=fall=0 throughout, reset_out falls on 4th edge after reset sampled low.
REQ-030 din[0] 1->0 held -> dout[0]=0 exactly 6 edges later, fall[0] high exactly that one cycle, dout[1]/rise/fall[1] unchanged.
REQ-031 din[0] low for 3 clocks then high -> no dout/pulse change; low for 4 clocks -> dout[0] goes 0 then back to 1, one fall and one rise.
REQ-032 din[1] 1->0, reset asserted when filter count = 2 -> dout=2'b11, no fall[1], counter 0; after release, din[1] still low -> fall[1] 6 edges after release.
REQ-033 reset re-asserted 1 cycle into hold -> reset_out stays high, falls 4 edges after the second release.
REQ-034 FILTER_CYCLES=0 build: din[0] 1->0 -> dout[0]=0 exactly 3 edges later; 1-cycle glitch passes through.
